twiddle_sequencer: RTL and testbench

Sequencer for the reduced twiddle table in the R2²SDF pipeline.
- Counts input samples within each stage frame and computes the twiddle exponent for the sample.
- Drives the table-reduction logic: the original address, plus the same address delayed by the table-read latency for data selection.
- Emits a valid strobe aligned with the reduced twiddle value and a frame-done pulse.
- Sits between the SDF unit's data-enable and the butterfly multiplier.

---
 rtl/twiddle_sequencer_if.sv | 25 ++
 rtl/twiddle_sequencer.sv | 165 ++++++++++++++++
 tb/tb_twiddle_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/twiddle_sequencer_if.sv
// Bundles the sample strobe, stage size and the twiddle-table control
// outputs of twiddle_sequencer. The master drives samples in; the slave
// (the sequencer) returns addresses and strobes.
interface twiddle_sequencer_if #(
   parameter int NN = 6
);
   logic          di_en;
   logic [3:0]    stage_lm;
   logic [NN-1:0] taddr;
   logic [NN-1:0] taddr_sel;
   logic          tw_en;
   logic          tw_triv;
   logic          frame_done;
   logic          busy;

   modport master (
      output di_en, stage_lm,
      input  taddr, taddr_sel, tw_en, tw_triv, frame_done, busy
   );

   modport slave (
      input  di_en, stage_lm,
      output taddr, taddr_sel, tw_en, tw_triv, frame_done, busy
   );
endinterface

// File: rtl/twiddle_sequencer.sv
// Twiddle sequencer for the reduced twiddle table of an R2^2 SDF stage.
// Counts samples within a frame of M = 2^lm, forms the exponent
// e = sel(q) * k, issues the table address one cycle after the sample and
// a copy delayed by ROM_LAT cycles (with valid / last / trivial flags)
// for data selection behind the table read.
// Optional feature macro: TWSEQ_TRIVIAL_EN (drives tw_triv when e == 0;
// when undefined tw_triv is tied low).
module twiddle_sequencer #(
   parameter int NN      = 6,
   parameter int ROM_LAT = 1
) (
   input  logic                clock,
   input  logic                reset,
   twiddle_sequencer_if.slave  bus
);

   localparam logic [3:0] NN_LM = 4'(NN);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state;
   logic          busy_r;
   logic [NN-1:0] cnt;
   logic [3:0]    lm_r;

   logic [3:0]    lm_eff;
   logic          last_samp;
   logic [NN-1:0] e_next;
   logic [NN-1:0] taddr_next;
   logic          upstream_vld;

   logic [NN-1:0] taddr_p0;
   logic          vld_p0;
   logic          last_p0;
   logic [NN-1:0] taddr_p1 [ROM_LAT];
   logic          vld_p1   [ROM_LAT];
   logic          last_p1  [ROM_LAT];

   // Clamp the requested stage size into the supported range [2, NN].
   function automatic logic [3:0] clamp_lm(input logic [3:0] v);
      if (v < 4'd2)       return 4'd2;
      else if (v > NN_LM) return NN_LM;
      else                return v;
   endfunction

   // Low-bit mask of width n: 2^n - 1.
   function automatic logic [NN-1:0] low_mask(input logic [3:0] n);
      return NN'(((NN+1)'(1) << n) - (NN+1)'(1));
   endfunction

   function automatic logic bit_at(input logic [NN-1:0] c, input logic [3:0] pos);
      return |(c & (NN'(1) << pos));
   endfunction

   // e = sel * k with q = c[lm-1:lm-2], sel = {q[0], q[1]}, k = c[lm-3:0].
   function automatic logic [NN-1:0] twiddle_exp(input logic [NN-1:0] c,
                                                 input logic [3:0]    lm);
      logic [1:0]    sel;
      logic [NN-1:0] k;
      sel = {bit_at(c, lm - 4'd2), bit_at(c, lm - 4'd1)};
      k   = c & low_mask(lm - 4'd2);
      return NN'(sel) * k;
   endfunction

   // Effective stage size (fresh latch on count 0), exponent and address.
   always_comb begin
      lm_eff       = (cnt == '0) ? clamp_lm(bus.stage_lm) : lm_r;
      last_samp    = (cnt == low_mask(lm_eff));
      e_next       = twiddle_exp(cnt, lm_eff);
      taddr_next   = e_next << (NN_LM - lm_eff);
      upstream_vld = vld_p0;
      for (int i = 0; i < ROM_LAT - 1; i++) begin
         upstream_vld = upstream_vld | vld_p1[i];
      end
   end

   // Frame control: state, busy flag, sample counter and stage latch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         cnt    <= '0;
         lm_r   <= NN_LM;
      end else begin
         if (bus.di_en) begin
            cnt <= last_samp ? '0 : cnt + NN'(1);
            if (cnt == '0) lm_r <= lm_eff;
         end
         case (state)
            IDLE: if (bus.di_en) begin
               state  <= last_samp ? DRAIN : RUN;
               busy_r <= 1'b1;
            end
            RUN: if (bus.di_en && last_samp) state <= DRAIN;
            DRAIN: begin
               if (bus.di_en) begin
                  state <= last_samp ? DRAIN : RUN;
               end else if (last_p1[ROM_LAT-1] && !upstream_vld) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Stage p0: registered table address; holds between samples.
   // Stage p1: ROM_LAT-deep delay line aligned with the table read.
   always_ff @(posedge clock) begin
      if (reset) begin
         taddr_p0 <= '0;
         vld_p0   <= 1'b0;
         last_p0  <= 1'b0;
         for (int i = 0; i < ROM_LAT; i++) begin
            taddr_p1[i] <= '0;
            vld_p1[i]   <= 1'b0;
            last_p1[i]  <= 1'b0;
         end
      end else begin
         if (bus.di_en) taddr_p0 <= taddr_next;
         vld_p0      <= bus.di_en;
         last_p0     <= bus.di_en & last_samp;
         taddr_p1[0] <= taddr_p0;
         vld_p1[0]   <= vld_p0;
         last_p1[0]  <= last_p0;
         for (int i = 1; i < ROM_LAT; i++) begin
            taddr_p1[i] <= taddr_p1[i-1];
            vld_p1[i]   <= vld_p1[i-1];
            last_p1[i]  <= last_p1[i-1];
         end
      end
   end

`ifdef TWSEQ_TRIVIAL_EN
   logic triv_p0;
   logic triv_p1 [ROM_LAT];

   // Trivial-twiddle flag (e == 0) travelling with the valid strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         triv_p0 <= 1'b0;
         for (int i = 0; i < ROM_LAT; i++) triv_p1[i] <= 1'b0;
      end else begin
         triv_p0    <= bus.di_en & (e_next == '0);
         triv_p1[0] <= triv_p0;
         for (int i = 1; i < ROM_LAT; i++) triv_p1[i] <= triv_p1[i-1];
      end
   end

   assign bus.tw_triv = triv_p1[ROM_LAT-1];
`else
   assign bus.tw_triv = 1'b0;
`endif

   assign bus.taddr      = taddr_p0;
   assign bus.taddr_sel  = taddr_p1[ROM_LAT-1];
   assign bus.tw_en      = vld_p1[ROM_LAT-1];
   assign bus.frame_done = last_p1[ROM_LAT-1];
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed bench for twiddle_sequencer (NN=6, ROM_LAT=1): a vector table of
// single-sample address checks plus hand-written multi-cycle sequences.
module tb_twiddle_sequencer;

`ifdef TWSEQ_TRIVIAL_EN
   localparam bit TRIV_ON = 1'b1;
`else
   localparam bit TRIV_ON = 1'b0;
`endif

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   twiddle_sequencer_if #(.NN(6)) bus ();

   twiddle_sequencer #(.NN(6), .ROM_LAT(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int lm;
      int cnt;
      int addr;
      int triv;
      int fd;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic en);
      bus.di_en = en;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1'b0);
      tick(1'b0);
      reset = 1'b0;
   endtask

   // Reference address: arithmetic form of the exponent definition.
   function automatic int ref_addr(input int c, input int lm_in);
      int lm, h, q, sel, k;
      lm  = (lm_in < 2) ? 2 : ((lm_in > 6) ? 6 : lm_in);
      h   = 1 << (lm - 2);
      q   = (c / h) % 4;
      sel = (q == 1) ? 2 : ((q == 2) ? 1 : q);
      k   = c % h;
      return (sel * k) * (1 << (6 - lm));
   endfunction

   initial begin
      int fd_cnt;
      int en_pat [9];
      int tw_pat [9];
      int exp_en;

      checks   = 0;
      failures = 0;
      bus.di_en    = 1'b0;
      bus.stage_lm = 4'd6;

      vecs[0]  = '{6,  0,  0, 1, 0};
      vecs[1]  = '{6, 17,  2, 0, 0};
      vecs[2]  = '{6, 35,  3, 0, 0};
      vecs[3]  = '{6, 63, 45, 0, 1};
      vecs[4]  = '{4,  5,  8, 0, 0};
      vecs[5]  = '{4, 15, 36, 0, 1};
      vecs[6]  = '{4,  3,  0, 1, 0};
      vecs[7]  = '{9, 17,  2, 0, 0};
      vecs[8]  = '{9, 63, 45, 0, 1};
      vecs[9]  = '{1,  3,  0, 1, 1};
      vecs[10] = '{5, 29, 30, 0, 0};
      vecs[11] = '{5, 31, 42, 0, 1};

      en_pat = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
      tw_pat = '{0, 1, 0, 0, 1, 1, 0, 1, 0};

      // Reset held with di_en high
      reset = 1'b1;
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      check("rst_taddr", bus.taddr, 0);
      check("rst_taddr_sel", bus.taddr_sel, 0);
      check("rst_tw_en", bus.tw_en, 0);
      check("rst_tw_triv", bus.tw_triv, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b0;
      tick(1'b1);
      check("post_rst_taddr", bus.taddr, 0);
      check("post_rst_busy", bus.busy, 1);

      // Vector table: drive cnt+1 samples, check address then delayed copy
      for (int v = 0; v < 12; v++) begin
         do_reset();
         bus.stage_lm = 4'(vecs[v].lm);
         for (int i = 0; i <= vecs[v].cnt; i++) tick(1'b1);
         check($sformatf("vec%0d_taddr", v), bus.taddr, vecs[v].addr);
         tick(1'b0);
         check($sformatf("vec%0d_tw_en", v), bus.tw_en, 1);
         check($sformatf("vec%0d_taddr_sel", v), bus.taddr_sel, vecs[v].addr);
         check($sformatf("vec%0d_tw_triv", v), bus.tw_triv, TRIV_ON ? vecs[v].triv : 0);
         check($sformatf("vec%0d_frame_done", v), bus.frame_done, vecs[v].fd);
      end

      // Full-size stage: 64 consecutive samples
      do_reset();
      bus.stage_lm = 4'd6;
      for (int j = 0; j < 66; j++) begin
         tick(j < 64);
         if (j < 16) check("full_taddr_low", bus.taddr, 0);
         else if (j < 64) check("full_taddr", bus.taddr, ref_addr(j, 6));
         exp_en = (j >= 1 && j <= 64) ? 1 : 0;
         check("full_tw_en", bus.tw_en, exp_en);
         check("full_frame_done", bus.frame_done, (j == 64) ? 1 : 0);
         if (exp_en == 1) begin
            check("full_taddr_sel", bus.taddr_sel, ref_addr(j - 1, 6));
            check("full_tw_triv", bus.tw_triv,
                  (TRIV_ON && ref_addr(j - 1, 6) == 0) ? 1 : 0);
         end
      end
      check("full_busy_end", bus.busy, 0);

      // Scaled stage: 4 back-to-back frames of 16
      do_reset();
      bus.stage_lm = 4'd4;
      fd_cnt = 0;
      for (int j = 0; j < 66; j++) begin
         tick(j < 64);
         if (bus.frame_done) fd_cnt++;
         exp_en = (j >= 1 && j <= 64) ? 1 : 0;
         check("b2b_tw_en", bus.tw_en, exp_en);
         check("b2b_frame_done", bus.frame_done,
               (exp_en == 1 && ((j - 1) % 16) == 15) ? 1 : 0);
         if (exp_en == 1) check("b2b_taddr_sel", bus.taddr_sel, ref_addr((j - 1) % 16, 4));
         if (j >= 1 && j <= 64) check("b2b_busy", bus.busy, 1);
      end
      check("b2b_fd_count", fd_cnt, 4);

      // Gaps in di_en reproduce on tw_en two cycles later
      do_reset();
      bus.stage_lm = 4'd6;
      for (int j = 0; j < 9; j++) begin
         tick(en_pat[j] != 0);
         check("gap_tw_en", bus.tw_en, tw_pat[j]);
      end

      // stage_lm=1 clamps to 2: frame_done every 4 samples
      do_reset();
      bus.stage_lm = 4'd1;
      fd_cnt = 0;
      for (int j = 0; j < 14; j++) begin
         tick(j < 12);
         if (bus.frame_done) fd_cnt++;
         check("lm1_frame_done", bus.frame_done,
               (j >= 1 && j <= 12 && ((j - 1) % 4) == 3) ? 1 : 0);
      end
      check("lm1_fd_count", fd_cnt, 3);

      // Mid-frame stage change is ignored until the next frame
      do_reset();
      bus.stage_lm = 4'd6;
      for (int j = 0; j < 82; j++) begin
         if (j == 20) bus.stage_lm = 4'd4;
         tick(j < 80);
         if (j == 35) check("midlm_taddr35", bus.taddr, 3);
         if (j == 69) check("midlm_next_c5", bus.taddr, 8);
         check("midlm_frame_done", bus.frame_done, (j == 64 || j == 80) ? 1 : 0);
      end

      // Reset mid-frame discards the partial frame
      do_reset();
      bus.stage_lm = 4'd6;
      for (int j = 0; j < 21; j++) tick(1'b1);
      check("midrst_taddr_c20", bus.taddr, 8);
      reset = 1'b1;
      tick(1'b0);
      check("midrst_tw_en", bus.tw_en, 0);
      check("midrst_frame_done", bus.frame_done, 0);
      check("midrst_taddr", bus.taddr, 0);
      reset = 1'b0;
      tick(1'b0);
      check("midrst_frame_done2", bus.frame_done, 0);
      check("midrst_busy", bus.busy, 0);
      bus.stage_lm = 4'd4;
      tick(1'b1);
      check("midrst_first_taddr", bus.taddr, 0);
      for (int j = 1; j <= 5; j++) tick(1'b1);
      check("midrst_relatch_c5", bus.taddr, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
